// File: rtl/timer_irq_device.sv
// rtl/timer_irq_device.sv - memory-mapped timer with prescaler, compare match and level interrupt
// Single-cycle bus slave: every request completes with a ready_o pulse one cycle later.
module timer_irq_device #(
  parameter int PRESC_WIDTH = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        write_enable_i,
  input  logic [31:0] addr_i,
  input  logic [2:0]  size_i,
  input  logic [31:0] write_data_i,
  output logic [31:0] read_data_o,
  output logic        ready_o,
  output logic        irq_req_o,
  input  logic        irq_ret_i
);

  localparam logic [2:0] SEL_CNT    = 3'd0;
  localparam logic [2:0] SEL_CMP    = 3'd1;
  localparam logic [2:0] SEL_CTRL   = 3'd2;
  localparam logic [2:0] SEL_PRESC  = 3'd3;
  localparam logic [2:0] SEL_STATUS = 3'd4;

  logic [31:0]            cnt_q;
  logic [31:0]            cmp_q;
  logic                   en_q;
  logic                   periodic_q;
  logic [PRESC_WIDTH-1:0] presc_q;
  logic [PRESC_WIDTH-1:0] pcnt_q;
  logic                   pend_q;

  logic [2:0]  reg_sel;
  logic        size_ok;
  logic        wr_ok;
  logic        wr_cnt;
  logic        wr_cmp;
  logic        wr_ctrl;
  logic        wr_presc;
  logic        status_clr;
  logic        tick;
  logic [31:0] cnt_inc;
  logic        match;
  logic [31:0] rd_mux;
  logic        unused_addr_bits;

  assign reg_sel    = addr_i[4:2];
  assign size_ok    = (size_i == 3'd2);
  assign wr_ok      = req_i && write_enable_i && size_ok;
  assign wr_cnt     = wr_ok && (reg_sel == SEL_CNT);
  assign wr_cmp     = wr_ok && (reg_sel == SEL_CMP);
  assign wr_ctrl    = wr_ok && (reg_sel == SEL_CTRL);
  assign wr_presc   = wr_ok && (reg_sel == SEL_PRESC);
  assign status_clr = wr_ok && (reg_sel == SEL_STATUS) && write_data_i[0];

  assign unused_addr_bits = ^{addr_i[31:5], addr_i[1:0]};

  // A CNT write overrides the tick and suppresses the compare for that cycle.
  assign tick    = en_q && (pcnt_q == presc_q);
  assign cnt_inc = cnt_q + 32'd1;
  assign match   = tick && !wr_cnt && (cnt_inc == cmp_q);

  always_comb begin
    rd_mux = 32'd0;
    if (size_ok) begin
      case (reg_sel)
        SEL_CNT:    rd_mux = cnt_q;
        SEL_CMP:    rd_mux = cmp_q;
        SEL_CTRL:   rd_mux = {30'd0, periodic_q, en_q};
        SEL_PRESC:  rd_mux = 32'(presc_q);
        SEL_STATUS: rd_mux = {31'd0, pend_q};
        default:    rd_mux = 32'd0;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      cnt_q       <= '0;
      cmp_q       <= '0;
      en_q        <= 1'b0;
      periodic_q  <= 1'b0;
      presc_q     <= '0;
      pcnt_q      <= '0;
      pend_q      <= 1'b0;
      read_data_o <= '0;
      ready_o     <= 1'b0;
    end else begin
      ready_o <= req_i;
      if (req_i && !write_enable_i) begin
        read_data_o <= rd_mux;
      end

      if (!en_q) begin
        pcnt_q <= '0;
      end else if (tick) begin
        pcnt_q <= '0;
      end else begin
        pcnt_q <= pcnt_q + 1'b1;
      end

      if (wr_cnt) begin
        cnt_q <= write_data_i;
      end else if (tick) begin
        cnt_q <= (match && periodic_q) ? 32'd0 : cnt_inc;
      end

      if (wr_cmp) begin
        cmp_q <= write_data_i;
      end
      if (wr_ctrl) begin
        en_q       <= write_data_i[0];
        periodic_q <= write_data_i[1];
      end
      if (wr_presc) begin
        presc_q <= write_data_i[PRESC_WIDTH-1:0];
      end

      // A match beats any same-cycle clear.
      if (match) begin
        pend_q <= 1'b1;
      end else if (irq_ret_i || status_clr) begin
        pend_q <= 1'b0;
      end
    end
  end

  assign irq_req_o = pend_q;

endmodule

// File: tb/tb_timer_irq_device.sv
// tb/tb_timer_irq_device.sv - directed and randomized checks of timer_irq_device against a reference model
module tb_timer_irq_device;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        req_i = 1'b0;
  logic        write_enable_i = 1'b0;
  logic [31:0] addr_i = '0;
  logic [2:0]  size_i = 3'd2;
  logic [31:0] write_data_i = '0;
  logic [31:0] read_data_o;
  logic        ready_o;
  logic        irq_req_o;
  logic        irq_ret_i = 1'b0;

  always #5 clk_i = ~clk_i;

  timer_irq_device #(.PRESC_WIDTH(16)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .req_i          (req_i),
    .write_enable_i (write_enable_i),
    .addr_i         (addr_i),
    .size_i         (size_i),
    .write_data_i   (write_data_i),
    .read_data_o    (read_data_o),
    .ready_o        (ready_o),
    .irq_req_o      (irq_req_o),
    .irq_ret_i      (irq_ret_i)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Reference state: the programmer-visible registers plus the hidden prescale count.
  logic [31:0] m_cnt = '0, m_cmp = '0, m_rdata = '0;
  logic [15:0] m_presc = '0, m_pcnt = '0;
  logic        m_en = 0, m_per = 0, m_pend = 0, m_ready = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    logic        wr;
    logic [2:0]  sel;
    logic        tick;
    logic        hit;
    logic [31:0] nxt;
    wr   = req_i && write_enable_i && (size_i == 3'd2);
    sel  = addr_i[4:2];
    tick = m_en && (m_pcnt == m_presc);
    nxt  = m_cnt + 32'd1;
    hit  = tick && !(wr && sel == 3'd0) && (nxt == m_cmp);
    if (!rst_i) begin
      m_cnt = 0; m_cmp = 0; m_rdata = 0; m_presc = 0; m_pcnt = 0;
      m_en = 0; m_per = 0; m_pend = 0; m_ready = 0;
    end else begin
      m_ready = req_i;
      if (req_i && !write_enable_i) begin
        if (size_i != 3'd2) m_rdata = 0;
        else case (sel)
          3'd0: m_rdata = m_cnt;
          3'd1: m_rdata = m_cmp;
          3'd2: m_rdata = {30'd0, m_per, m_en};
          3'd3: m_rdata = {16'd0, m_presc};
          3'd4: m_rdata = {31'd0, m_pend};
          default: m_rdata = 0;
        endcase
      end
      m_pcnt = (m_en && !tick) ? m_pcnt + 16'd1 : 16'd0;
      if (wr && sel == 3'd0) m_cnt = write_data_i;
      else if (tick) m_cnt = (hit && m_per) ? 32'd0 : nxt;
      if (hit) m_pend = 1;
      else if (irq_ret_i || (wr && sel == 3'd4 && write_data_i[0])) m_pend = 0;
      if (wr && sel == 3'd1) m_cmp = write_data_i;
      if (wr && sel == 3'd2) begin m_en = write_data_i[0]; m_per = write_data_i[1]; end
      if (wr && sel == 3'd3) m_presc = write_data_i[15:0];
    end
  endtask

  task automatic cyc(input logic rst, input logic req, input logic we, input logic [31:0] addr,
                     input logic [2:0] size, input logic [31:0] wdata, input logic ret);
    rst_i = rst; req_i = req; write_enable_i = we; addr_i = addr;
    size_i = size; write_data_i = wdata; irq_ret_i = ret;
    @(posedge clk_i);
    model_edge();
    #1;
    chk("ready_o", {31'd0, ready_o}, {31'd0, m_ready});
    chk("irq_req_o", {31'd0, irq_req_o}, {31'd0, m_pend});
    chk("read_data_o", read_data_o, m_rdata);
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    cyc(1, 1, 1, addr, 3'd2, data, 0);
  endtask

  task automatic rd(input logic [31:0] addr);
    cyc(1, 1, 0, addr, 3'd2, 32'd0, 0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1, 0, 0, 32'd0, 3'd2, 32'd0, 0);
  endtask

  initial begin
    logic [31:0] tmp;
    logic [2:0]  sel;
    logic [31:0] wd;

    // Reset state
    cyc(0, 0, 0, 0, 3'd2, 0, 0);
    cyc(0, 1, 1, 32'h4, 3'd2, 32'h77, 0);
    chk("reset_ready", {31'd0, ready_o}, 32'd0);
    chk("reset_irq", {31'd0, irq_req_o}, 32'd0);
    for (int a = 0; a < 5; a++) begin
      rd(32'(a * 4));
      chk("reset_reg", read_data_o, 32'd0);
    end

    // Periodic interrupt
    wr(32'hC, 0); wr(32'h4, 3); wr(32'h8, 3);
    idle(2); chk("per_irq_early", {31'd0, irq_req_o}, 32'd0);
    idle(1); chk("per_irq_rise", {31'd0, irq_req_o}, 32'd1);
    cyc(1, 0, 0, 0, 3'd2, 0, 1); chk("per_ret_clr", {31'd0, irq_req_o}, 32'd0);
    idle(1); chk("per_still_low", {31'd0, irq_req_o}, 32'd0);
    idle(1); chk("per_reassert", {31'd0, irq_req_o}, 32'd1);
    rd(32'h0); chk("per_cnt_zero", read_data_o, 32'd0);

    // Prescaler
    wr(32'h8, 0); wr(32'h10, 1); wr(32'h0, 0);
    wr(32'hC, 2); wr(32'h4, 1); wr(32'h8, 1);
    idle(2); chk("presc_irq_early", {31'd0, irq_req_o}, 32'd0);
    idle(1); chk("presc_irq_rise", {31'd0, irq_req_o}, 32'd1);
    rd(32'h0); chk("presc_cnt1", read_data_o, 32'd1);
    idle(2);
    rd(32'h0); chk("presc_cnt2", read_data_o, 32'd2);

    // Wrap-around match
    wr(32'h8, 0); wr(32'hC, 0); wr(32'h4, 0); wr(32'h0, 32'hFFFF_FFFF);
    wr(32'h10, 1); wr(32'h8, 1);
    idle(1); chk("wrap_pend", {31'd0, irq_req_o}, 32'd1);
    rd(32'h0); chk("wrap_cnt", read_data_o, 32'd0);

    // Match beats irq_ret_i; STATUS write clears
    wr(32'h8, 0); wr(32'h4, 2); wr(32'h0, 0); wr(32'h8, 1);
    idle(1);
    cyc(1, 0, 0, 0, 3'd2, 0, 1); chk("match_vs_ret", {31'd0, irq_req_o}, 32'd1);
    wr(32'h10, 1); chk("status_clr", {31'd0, irq_req_o}, 32'd0);

    // CNT write beats a same-cycle tick and its match
    wr(32'h4, 5);
    wr(32'h0, 9); chk("cntwr_no_match", {31'd0, irq_req_o}, 32'd0);
    rd(32'h0); chk("cntwr_value", read_data_o, 32'd9);

    // Illegal accesses
    wr(32'h8, 0);
    cyc(1, 1, 1, 32'h4, 3'd0, 32'h55, 0); chk("bad_size_ready", {31'd0, ready_o}, 32'd1);
    rd(32'h4); chk("bad_size_cmp", read_data_o, 32'd5);
    rd(32'h1C); chk("unmapped_rd", read_data_o, 32'd0);
    cyc(1, 1, 0, 32'h4, 3'd1, 0, 0); chk("bad_size_rd", read_data_o, 32'd0);

    // Reset while counting with the interrupt pending
    wr(32'h0, 0); wr(32'h4, 1); wr(32'h8, 3);
    idle(2); chk("pre_rst_irq", {31'd0, irq_req_o}, 32'd1);
    cyc(0, 1, 1, 32'h4, 3'd2, 32'h1234, 0);
    chk("rst_irq", {31'd0, irq_req_o}, 32'd0);
    idle(1); chk("rst_no_ready", {31'd0, ready_o}, 32'd0);
    for (int a = 0; a < 5; a++) begin
      rd(32'(a * 4));
      chk("rst_reg", read_data_o, 32'd0);
    end

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      tmp = $urandom;
      sel = 3'($urandom_range(0, 7));
      case (sel)
        3'd0, 3'd1: wd = $urandom_range(0, 9);
        3'd2, 3'd3: wd = $urandom_range(0, 3);
        3'd4:       wd = {$urandom, 1'b0} >> 1 | 32'($urandom_range(0, 1));
        default:    wd = $urandom;
      endcase
      cyc(($urandom_range(0, 199) != 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          {tmp[31:5], sel, tmp[1:0]},
          ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7)) : 3'd2,
          wd, ($urandom_range(0, 15) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/timer_irq_device.md
TIMER_IRQ_DEVICE -- requirements
Module: timer_irq_device

Interface
REQ-001 The block SHALL use a single clock, with a synchronous, active-low reset.
REQ-002 The block SHALL have one parameter: PRESC_WIDTH, default 16, prescaler register width.
REQ-003 The block SHALL have the following ports, in this order:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-low reset
- req_i  in  1  bus access request
- write_enable_i  in  1  1 = write, 0 = read
- addr_i  in  32  byte address; only addr_i[4:2] is decoded
- size_i  in  3  access size; only 3'd2 (word) is legal
- write_data_i  in  32  write data
- read_data_o  out  32  registered read data
- ready_o  out  1  access-complete pulse
- irq_req_o  out  1  interrupt request to the core
- irq_ret_i  in  1  core mret acknowledge

Function
REQ-004 The register map (addr_i[4:2]) SHALL be:
- 0: CNT (RW, 32 bit)
- 1: CMP (RW, 32 bit)
- 2: CTRL (RW; bit0 EN, bit1 PERIODIC, other bits read 0)
- 3: PRESC (RW, PRESC_WIDTH bits, zero-extended on read)
- 4: STATUS (bit0 PEND; writing 1 to bit0 clears it)
- 5-7: unmapped
REQ-005 The prescale counter SHALL increment each cycle while EN=1; when it equals PRESC, it SHALL wrap to 0 and generate a tick the same cycle.
REQ-006 PRESC=0 SHALL give a tick every EN cycle.
REQ-007 On a tick, CNT SHALL increment by 1, with modulo 2^32 wrap-around (0xFFFF_FFFF -> 0).
REQ-008 A match SHALL occur when the incremented CNT value equals CMP; PEND SHALL be set in the cycle after the tick.
REQ-009 On a match with PERIODIC=1, CNT SHALL load 0 instead of the incremented value. With PERIODIC=0, counting SHALL continue, and the next match SHALL occur after the wrap.
REQ-010 EN=0 SHALL freeze CNT and the prescale counter. Clearing EN SHALL reset the prescale counter to 0.
REQ-011 irq_req_o SHALL equal PEND, held level-high until cleared.
REQ-012 PEND SHALL be cleared by irq_ret_i=1 or by a STATUS write with bit0=1.
REQ-013 If a match and a clear occur in the same cycle, the match SHALL win and PEND SHALL stay 1.
REQ-014 A CNT write SHALL take priority over a same-cycle tick: CNT takes write_data_i, and no match is evaluated that cycle.
REQ-015 A CMP write SHALL take effect from the next cycle's comparison.
REQ-016 A write SHALL be performed only when req_i=1, write_enable_i=1 and size_i=3'd2. Otherwise it SHALL be ignored, though ready_o still pulses.
REQ-017 read_data_o SHALL be registered. It SHALL be valid in the cycle after req_i with write_enable_i=0, and hold its value until the next read.
REQ-018 Reads of unmapped addresses or with size_i != 3'd2 SHALL return 32'd0.
REQ-019 ready_o SHALL be 1 exactly one cycle after every cycle with req_i=1, giving a fixed 1-cycle latency with no wait states.
REQ-020 Back-to-back requests SHALL be accepted every cycle.
REQ-021 A CNT read SHALL return the pre-update value of the cycle in which req_i was sampled.

Reset
REQ-022 When rst_i=0 at a clock edge, the following SHALL all reset to 0: CNT, CMP, CTRL, PRESC, prescale counter, PEND, read_data_o, ready_o and irq_req_o.
REQ-023 Reset mid-count or with PEND=1 SHALL drop irq_req_o in the next cycle.
REQ-024 Bus requests presented during reset SHALL be ignored, with no ready_o pulse afterward.

Verification
REQ-025 Periodic interrupt: PRESC=0, CMP=3, CTRL=3 -> irq_req_o rises 4 cycles after EN is written, with CNT=0 at that point. irq_ret_i pulse -> irq_req_o=0 the next cycle, and it re-asserts 3 ticks later.
REQ-026 Prescaler: PRESC=2, CMP=1, CTRL=1 -> CNT increments every 3 cycles, and PEND sets after the 1st tick. A CNT read afterward returns 1, then 2, with no reload.
REQ-027 Wrap: CNT written to 0xFFFF_FFFF, CMP=0, PERIODIC=0, EN=1, PRESC=0 -> the next tick gives CNT=0 and PEND=1.
REQ-028 Simultaneous match and irq_ret_i with PEND already 1 -> PEND stays 1. A STATUS write of 1 with no match -> PEND=0.
REQ-029 Illegal accesses: size_i=3'd0 write to CMP -> CMP unchanged and ready_o pulses. A read of addr 0x1C -> read_data_o=0.
REQ-030 Reset: rst_i low for 1 cycle while irq_req_o=1 and counting -> all registers read 0 and irq_req_o=0.
